// File: rtl/render_scheduler_if.sv
// Bundle of the game-side inputs and VGA/status outputs of the render scheduler.
// The master modport is the scheduler's view. The slave modport is the game FSM / VGA adapter view.
`timescale 1ns/1ps
interface render_scheduler_if;
  logic       frame_tick;
  logic [7:0] obj0_x;
  logic [6:0] obj0_y;
  logic [2:0] obj0_col;
  logic [7:0] obj1_x;
  logic [6:0] obj1_y;
  logic [2:0] obj1_col;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic       collide;
  logic       overrun;

  modport master (
    input  frame_tick, obj0_x, obj0_y, obj0_col, obj1_x, obj1_y, obj1_col,
    output x, y, colour, plot, busy, done, collide, overrun
  );

  modport slave (
    output frame_tick, obj0_x, obj0_y, obj0_col, obj1_x, obj1_y, obj1_col,
    input  x, y, colour, plot, busy, done, collide, overrun
  );
endinterface

// File: rtl/render_scheduler.sv
// Per-frame sequencer sharing one VGA write port between two square sprites:
// it erases both objects at their old positions, draws both at the new positions, then reports collision.
`timescale 1ns/1ps
module render_scheduler #(
  parameter int unsigned SIZE_LOG2 = 2,
  parameter logic [2:0]  BG_COLOUR = 3'd0,
  parameter int unsigned X_MAX     = 159,
  parameter int unsigned Y_MAX     = 119
) (
  input  logic                clock,
  input  logic                resetn,
  render_scheduler_if.master  bus
);

  localparam int unsigned CW = 2 * SIZE_LOG2;
  localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
  localparam logic [8:0]    X_LIM    = 9'(X_MAX);
  localparam logic [7:0]    Y_LIM    = 8'(Y_MAX);
  localparam logic [7:0]    SIDE     = 8'(1 << SIZE_LOG2);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_ERASE0, S_ERASE1, S_DRAW0, S_DRAW1, S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } pos_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pos_t          new0_q, new0_d, new1_q, new1_d;
  logic [2:0]    col0_q, col0_d, col1_q, col1_d;
  pos_t          prev0_q, prev0_d, prev1_q, prev1_d;
  logic          prev_valid_q, prev_valid_d;
  logic          collide_q, collide_d;
  logic          overrun_q, overrun_d;

  logic [7:0]    base_x_s;
  logic [6:0]    base_y_s;
  logic [2:0]    base_col_s;
  logic          pix_state_s;
  logic [8:0]    sum_x_s;
  logic [7:0]    sum_y_s;
  logic          visible_s;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Unsigned-safe box overlap: both axis distances strictly below the sprite side.
  function automatic logic boxes_overlap(input pos_t a, input pos_t b);
    return (abs_diff(a.x, b.x) < SIDE) &&
           (abs_diff({1'b0, a.y}, {1'b0, b.y}) < SIDE);
  endfunction

  // Pixel decode from registered state only: pick the sprite base, then clip the widened sum.
  always_comb begin
    base_x_s    = 8'd0;
    base_y_s    = 7'd0;
    base_col_s  = 3'd0;
    pix_state_s = 1'b1;
    case (state_q)
      S_ERASE0: begin base_x_s = prev0_q.x; base_y_s = prev0_q.y; base_col_s = BG_COLOUR; end
      S_ERASE1: begin base_x_s = prev1_q.x; base_y_s = prev1_q.y; base_col_s = BG_COLOUR; end
      S_DRAW0:  begin base_x_s = new0_q.x;  base_y_s = new0_q.y;  base_col_s = col0_q;    end
      S_DRAW1:  begin base_x_s = new1_q.x;  base_y_s = new1_q.y;  base_col_s = col1_q;    end
      default:  pix_state_s = 1'b0;
    endcase
    sum_x_s   = {1'b0, base_x_s} + {{(9 - SIZE_LOG2){1'b0}}, cnt_q[SIZE_LOG2-1:0]};
    sum_y_s   = {1'b0, base_y_s} + {{(8 - SIZE_LOG2){1'b0}}, cnt_q[CW-1:SIZE_LOG2]};
    visible_s = (sum_x_s <= X_LIM) && (sum_y_s <= Y_LIM);
  end

  assign bus.plot    = pix_state_s & visible_s;
  assign bus.x       = pix_state_s ? sum_x_s[7:0] : 8'd0;
  assign bus.y       = pix_state_s ? sum_y_s[6:0] : 7'd0;
  assign bus.colour  = pix_state_s ? base_col_s   : 3'd0;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.collide = collide_q;
  assign bus.overrun = overrun_q;

  // Next-state logic: frame sequencing, pixel counter, and latching of positions and status.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    new0_d       = new0_q;
    new1_d       = new1_q;
    col0_d       = col0_q;
    col1_d       = col1_q;
    prev0_d      = prev0_q;
    prev1_d      = prev1_q;
    prev_valid_d = prev_valid_q;
    collide_d    = collide_q;
    overrun_d    = overrun_q;

    if (bus.frame_tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.frame_tick) begin
          state_d = S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        new0_d  = '{x: bus.obj0_x, y: bus.obj0_y};
        new1_d  = '{x: bus.obj1_x, y: bus.obj1_y};
        col0_d  = bus.obj0_col;
        col1_d  = bus.obj1_col;
        cnt_d   = {CW{1'b0}};
        state_d = prev_valid_q ? S_ERASE0 : S_DRAW0;
      end
      S_ERASE0, S_ERASE1, S_DRAW0, S_DRAW1: begin
        cnt_d = cnt_q + {{(CW - 1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          case (state_q)
            S_ERASE0: state_d = S_ERASE1;
            S_ERASE1: state_d = S_DRAW0;
            S_DRAW0:  state_d = S_DRAW1;
            default:  state_d = S_DONE;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_DONE: begin
        prev0_d      = new0_q;
        prev1_d      = new1_q;
        prev_valid_d = 1'b1;
        collide_d    = boxes_overlap(new0_q, new1_q);
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      new0_q       <= '0;
      new1_q       <= '0;
      col0_q       <= 3'd0;
      col1_q       <= 3'd0;
      prev0_q      <= '0;
      prev1_q      <= '0;
      prev_valid_q <= 1'b0;
      collide_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      new0_q       <= new0_d;
      new1_q       <= new1_d;
      col0_q       <= col0_d;
      col1_q       <= col1_d;
      prev0_q      <= prev0_d;
      prev1_q      <= prev1_d;
      prev_valid_q <= prev_valid_d;
      collide_q    <= collide_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_render_scheduler.sv
// Scoreboard bench for render_scheduler: expected pixels are queued when a frame is launched
// and compared against every plotted pixel; frame length, done, collide and overrun are checked per frame.
`timescale 1ns/1ps
module tb_render_scheduler;

  logic clock;
  logic resetn;
  render_scheduler_if bus ();

  render_scheduler dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] sb_q[$];

  logic       prev_valid_m = 1'b0;
  logic [7:0] prev0_x_m, prev1_x_m;
  logic [6:0] prev0_y_m, prev1_y_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the visible pixels of one 4x4 sprite in row-major order.
  task automatic push_sprite(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col,
                             output int n);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      int sx = int'(bx) + (k % 4);
      int sy = int'(by) + (k / 4);
      if (sx <= 159 && sy <= 119) begin
        sb_q.push_back({8'(sx), 7'(sy), col});
        n++;
      end
    end
  endtask

  // Pixel monitor: every plot is compared against the scoreboard; the idle bus must be all zero.
  always @(negedge clock) begin
    if (resetn) begin
      if (bus.plot) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          check_eq("pixel", {14'd0, bus.x, bus.y, bus.colour}, {14'd0, sb_q.pop_front()});
        end
      end else if (!bus.busy) begin
        check_eq("idle_bus", {13'd0, bus.plot, bus.x, bus.y, bus.colour}, 32'd0);
      end
    end
  end

  task automatic set_objs(input logic [7:0] x0, input logic [6:0] y0, input logic [2:0] c0,
                          input logic [7:0] x1, input logic [6:0] y1, input logic [2:0] c1);
    bus.obj0_x = x0; bus.obj0_y = y0; bus.obj0_col = c0;
    bus.obj1_x = x1; bus.obj1_y = y1; bus.obj1_col = c1;
  endtask

  task automatic run_frame(input logic [7:0] x0, input logic [6:0] y0, input logic [2:0] c0,
                           input logic [7:0] x1, input logic [6:0] y1, input logic [2:0] c1,
                           input int tick_at, input logic exp_collide, input logic exp_overrun);
    int n, pushed, exp_busy, busy_cnt, plot_cnt, done_cnt, cyc;
    pushed = 0;
    exp_busy = prev_valid_m ? 66 : 34;
    if (prev_valid_m) begin
      push_sprite(prev0_x_m, prev0_y_m, 3'd0, n); pushed += n;
      push_sprite(prev1_x_m, prev1_y_m, 3'd0, n); pushed += n;
    end
    push_sprite(x0, y0, c0, n); pushed += n;
    push_sprite(x1, y1, c1, n); pushed += n;

    @(negedge clock);
    set_objs(x0, y0, c0, x1, y1, c1);
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    busy_cnt = 0; plot_cnt = 0; done_cnt = 0; cyc = 0;
    while (bus.busy && cyc < 200) begin
      busy_cnt++;
      if (bus.plot) plot_cnt++;
      if (bus.done) done_cnt++;
      if (busy_cnt == 2) begin
        set_objs(8'($urandom), 7'($urandom), 3'($urandom), 8'($urandom), 7'($urandom), 3'($urandom));
      end
      bus.frame_tick = (tick_at > 0 && busy_cnt == tick_at);
      @(negedge clock);
      cyc++;
    end
    bus.frame_tick = 1'b0;
    check_eq("busy_len", 32'(busy_cnt), 32'(exp_busy));
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("plot_count", 32'(plot_cnt), 32'(pushed));
    check_eq("sb_left", 32'(sb_q.size()), 32'd0);
    check_eq("collide", {31'd0, bus.collide}, {31'd0, exp_collide});
    check_eq("overrun", {31'd0, bus.overrun}, {31'd0, exp_overrun});
    repeat (3) @(negedge clock);
    check_eq("no_restart", {31'd0, bus.busy}, 32'd0);
    sb_q.delete();
    prev_valid_m = 1'b1;
    prev0_x_m = x0; prev0_y_m = y0;
    prev1_x_m = x1; prev1_y_m = y1;
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    bus.frame_tick = 1'b0;
    set_objs(8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
    repeat (3) @(negedge clock);
    check_eq("reset_outs", {24'd0, bus.plot, bus.busy, bus.done, bus.collide, bus.overrun, bus.colour},
             32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("post_reset_busy", {31'd0, bus.busy}, 32'd0);

    run_frame(8'd10, 7'd58, 3'd2, 8'd50, 7'd20, 3'd4, 0, 1'b0, 1'b0);
    run_frame(8'd11, 7'd58, 3'd2, 8'd50, 7'd20, 3'd4, 0, 1'b0, 1'b0);
    run_frame(8'd157, 7'd118, 3'd3, 8'd50, 7'd20, 3'd4, 0, 1'b0, 1'b0);
    run_frame(8'd20, 7'd30, 3'd5, 8'd23, 7'd33, 3'd6, 0, 1'b1, 1'b0);
    run_frame(8'd20, 7'd30, 3'd5, 8'd24, 7'd33, 3'd6, 0, 1'b0, 1'b0);
    run_frame(8'd0, 7'd0, 3'd7, 8'd156, 7'd116, 3'd1, 10, 1'b0, 1'b1);

    // Reset in the middle of DRAW0 must drop plot and busy at once.
    push_sprite(prev0_x_m, prev0_y_m, 3'd0, n);
    push_sprite(prev1_x_m, prev1_y_m, 3'd0, n);
    push_sprite(8'd40, 7'd40, 3'd2, n);
    @(negedge clock);
    set_objs(8'd40, 7'd40, 3'd2, 8'd80, 7'd80, 3'd3);
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    repeat (40) @(negedge clock);
    check_eq("mid_draw_plot", {31'd0, bus.plot}, 32'd1);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_plot", {31'd0, bus.plot}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    sb_q.delete();
    @(negedge clock);
    resetn = 1'b1;
    prev_valid_m = 1'b0;
    repeat (2) @(negedge clock);
    run_frame(8'd60, 7'd60, 3'd1, 8'd62, 7'd61, 3'd2, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
